// File: rtl/pow_target_checker.sv
// Proof-of-work target checker: serial leading-zero count of a candidate, one chunk per cycle.
// Optional macro POW_EARLY_EXIT_EN ends the scan as soon as the running count meets the target.
module pow_target_checker #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 32,
  parameter int CNT_W = 9,
  parameter int ATT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cand,
  input  logic             cand_valid,
  output logic             cand_ready,
  input  logic [CNT_W-1:0] difficulty,
  output logic             out_valid,
  output logic [CNT_W-1:0] lz_count,
  output logic             found,
  output logic             solved,
  output logic [WIDTH-1:0] winner,
  output logic [ATT_W-1:0] attempts
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ATT_W-1:0] attempts_q, attempts_d;
  logic [CNT_W-1:0] lz_q, lz_d;
  logic             found_q, found_d;
  logic             solved_q, solved_d;
  logic [WIDTH-1:0] winner_q, winner_d;

  logic [CHUNK-1:0] chunk;
  logic             chunk_zero;
  logic [CNT_W-1:0] chunk_lz;
  logic [CNT_W-1:0] acc_upd;
  logic             finish;

  // Leading zeros of the top chunk; the highest set bit is the last writer.
  always_comb begin
    chunk      = shreg_q[WIDTH-1 -: CHUNK];
    chunk_zero = (chunk == '0);
    chunk_lz   = CNT_W'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) chunk_lz = CNT_W'(CHUNK - 1 - i);
    end
    acc_upd = acc_q + chunk_lz;
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cand_d     = cand_q;
    diff_d     = diff_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    attempts_d = attempts_q;
    lz_d       = lz_q;
    found_d    = found_q;
    solved_d   = solved_q;
    winner_d   = winner_q;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          shreg_d = cand;
          cand_d  = cand;
          diff_d  = difficulty;
          acc_d   = '0;
          idx_d   = '0;
          if (attempts_q != '1) attempts_d = attempts_q + ATT_W'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_upd;
        if (chunk_zero) begin
          shreg_d = shreg_q << CHUNK;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NCHUNK - 1)) finish = 1'b1;
        end else begin
          finish = 1'b1;
        end
`ifdef POW_EARLY_EXIT_EN
        if (acc_upd >= diff_q) finish = 1'b1;
`else
`endif
        // Result registers load on the way into DONE so they are stable during the pulse.
        if (finish) begin
          lz_d    = acc_upd;
          found_d = (acc_upd >= diff_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (found_q && !solved_q) begin
          winner_d = cand_q;
          solved_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cand_q     <= '0;
      diff_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      attempts_q <= '0;
      lz_q       <= '0;
      found_q    <= 1'b0;
      solved_q   <= 1'b0;
      winner_q   <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cand_q     <= cand_d;
      diff_q     <= diff_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      attempts_q <= attempts_d;
      lz_q       <= lz_d;
      found_q    <= found_d;
      solved_q   <= solved_d;
      winner_q   <= winner_d;
    end
  end

  assign cand_ready = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign lz_count   = lz_q;
  assign found      = found_q;
  assign solved     = solved_q;
  assign winner     = winner_q;
  assign attempts   = attempts_q;

endmodule

// File: tb/tb_pow_target_checker.sv
// Directed bench for pow_target_checker; expectations are hand-computed leading-zero counts.
// Early-exit expectations are selected by POW_EARLY_EXIT_EN.
module tb_pow_target_checker;

  logic         clk;
  logic         reset;
  logic [255:0] cand;
  logic         cand_valid;
  logic         cand_ready;
  logic [8:0]   difficulty;
  logic         out_valid;
  logic [8:0]   lz_count;
  logic         found;
  logic         solved;
  logic [255:0] winner;
  logic [31:0]  attempts;

  int vectors;
  int miscompares;

  pow_target_checker dut (
    .clk        (clk),
    .reset      (reset),
    .cand       (cand),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .difficulty (difficulty),
    .out_valid  (out_valid),
    .lz_count   (lz_count),
    .found      (found),
    .solved     (solved),
    .winner     (winner),
    .attempts   (attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one candidate, then count edges until out_valid appears (-1 on timeout).
  task automatic apply_stimulus(input logic [255:0] c, input logic [8:0] d, output int scan_edges);
    logic hit;
    @(negedge clk);
    cand       = c;
    difficulty = d;
    cand_valid = 1'b1;
    @(posedge clk);
    #1;
    cand_valid = 1'b0;
    check_output("ready_low_after_accept", 256'(cand_ready), 256'(0));
    scan_edges = -1;
    hit = 1'b0;
    for (int n = 1; n <= 20 && !hit; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        scan_edges = n;
        hit = 1'b1;
      end
    end
  endtask

  task automatic step_past_done();
    @(posedge clk);
    #1;
    check_output("pulse_one_cycle", 256'(out_valid), 256'(0));
    check_output("ready_back_in_idle", 256'(cand_ready), 256'(1));
  endtask

  logic [255:0] cand_a;
  logic [255:0] cand_ff;
  logic [255:0] cand_msb;
  int           edges;
  logic         saw_valid;

  initial begin
    vectors     = 0;
    miscompares = 0;
    cand        = '0;
    cand_valid  = 1'b0;
    difficulty  = '0;
    cand_a      = {32'h0, 32'h1, {192{1'b1}}};
    cand_ff     = 256'hFF;
    cand_msb    = {1'b1, 255'b0};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ready", 256'(cand_ready), 256'(1));
    check_output("rst_out_valid", 256'(out_valid), 256'(0));
    check_output("rst_lz", 256'(lz_count), 256'(0));
    check_output("rst_found", 256'(found), 256'(0));
    check_output("rst_solved", 256'(solved), 256'(0));
    check_output("rst_winner", winner, 256'(0));
    check_output("rst_attempts", 256'(attempts), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    // Abort a scan of the all-zero word with reset.
    @(negedge clk);
    cand       = '0;
    difficulty = 9'd0;
    cand_valid = 1'b1;
    @(posedge clk);
    #1;
    cand_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output("midscan_attempts_before", 256'(attempts), 256'(1));
    reset = 1'b1;
    #1;
    check_output("midscan_ready", 256'(cand_ready), 256'(1));
    check_output("midscan_out_valid", 256'(out_valid), 256'(0));
    check_output("midscan_lz", 256'(lz_count), 256'(0));
    check_output("midscan_found", 256'(found), 256'(0));
    check_output("midscan_attempts", 256'(attempts), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_output("midscan_no_pulse", 256'(saw_valid), 256'(0));

    // 63 leading zeros against a target of 64.
    apply_stimulus(cand_a, 9'd64, edges);
    check_output("a64_scan_edges", 256'(edges), 256'(2));
    check_output("a64_lz", 256'(lz_count), 256'(63));
    check_output("a64_found", 256'(found), 256'(0));
    step_past_done();
    check_output("a64_solved", 256'(solved), 256'(0));
    check_output("a64_attempts", 256'(attempts), 256'(1));

    apply_stimulus(cand_a, 9'd63, edges);
    check_output("a63_scan_edges", 256'(edges), 256'(2));
    check_output("a63_lz", 256'(lz_count), 256'(63));
    check_output("a63_found", 256'(found), 256'(1));
    step_past_done();
    check_output("a63_solved", 256'(solved), 256'(1));
    check_output("a63_winner", winner, cand_a);
    check_output("a63_attempts", 256'(attempts), 256'(2));

    // A second winner must not replace the first.
    apply_stimulus(cand_ff, 9'd0, edges);
`ifdef POW_EARLY_EXIT_EN
    check_output("ff_scan_edges", 256'(edges), 256'(1));
    check_output("ff_lz", 256'(lz_count), 256'(32));
`else
    check_output("ff_scan_edges", 256'(edges), 256'(8));
    check_output("ff_lz", 256'(lz_count), 256'(248));
`endif
    check_output("ff_found", 256'(found), 256'(1));
    step_past_done();
    check_output("ff_winner_kept", winner, cand_a);
    check_output("ff_attempts", 256'(attempts), 256'(3));

    apply_stimulus(256'(0), 9'd256, edges);
    check_output("z256_scan_edges", 256'(edges), 256'(8));
    check_output("z256_lz", 256'(lz_count), 256'(256));
    check_output("z256_found", 256'(found), 256'(1));
    step_past_done();
    check_output("z256_winner_kept", winner, cand_a);

    apply_stimulus(256'(0), 9'd257, edges);
    check_output("z257_scan_edges", 256'(edges), 256'(8));
    check_output("z257_lz", 256'(lz_count), 256'(256));
    check_output("z257_found", 256'(found), 256'(0));
    step_past_done();
    repeat (3) @(posedge clk);
    #1;
    check_output("hold_lz", 256'(lz_count), 256'(256));
    check_output("hold_found", 256'(found), 256'(0));
    check_output("z257_attempts", 256'(attempts), 256'(5));

    apply_stimulus(cand_msb, 9'd0, edges);
    check_output("msb_scan_edges", 256'(edges), 256'(1));
    check_output("msb_ready_in_done", 256'(cand_ready), 256'(0));
    check_output("msb_lz", 256'(lz_count), 256'(0));
    check_output("msb_found", 256'(found), 256'(1));
    step_past_done();
    check_output("msb_attempts", 256'(attempts), 256'(6));

`ifdef POW_EARLY_EXIT_EN
    apply_stimulus(256'(0), 9'd40, edges);
    check_output("early_scan_edges", 256'(edges), 256'(2));
    check_output("early_lz", 256'(lz_count), 256'(64));
    check_output("early_found", 256'(found), 256'(1));
    step_past_done();
`else
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
